// File: rtl/decoder_pkg.sv
// Shared constants for the RV32 decode stage: opcode values and the
// encodings of the ALU class and immediate-extension selector outputs.
package decoder_pkg;

    localparam int DEC_DATA_WIDTH = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_CMP = 5'b00001;
    localparam logic [4:0] ALU_INV = 5'b00111;

    localparam logic [2:0] SX_I12  = 3'b000;
    localparam logic [2:0] SX_J20  = 3'b110;
    localparam logic [2:0] SX_NONE = 3'b111;

endpackage

// File: rtl/decoder_imm_extract.sv
// Combinational immediate gather: reassembles the format's scattered immediate
// bits right-justified with zero upper bits, or 0 for unsupported opcodes.
module imm_extract
    import decoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEC_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] imm
);

    always_comb begin
        imm = '0;
        case (instruction[6:0])
            OP_LOAD, OP_JALR: imm[11:0] = instruction[31:20];
            OP_STORE:         imm[11:0] = {instruction[31:25], instruction[11:7]};
            // Branch and JAL immediates drop bit 0; the consumer shifts left by one.
            OP_BRANCH: imm[11:0] = {instruction[31], instruction[7],
                                    instruction[30:25], instruction[11:8]};
            OP_JAL:    imm[19:0] = {instruction[31], instruction[19:12],
                                    instruction[20], instruction[30:21]};
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/decoder.sv
// Registered RV32 decoder for load/store/branch/JAL/JALR; every other opcode
// decodes as invalid with all side effects disabled. One-cycle latency.
module decoder
    import decoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEC_DATA_WIDTH,
    localparam int REG_W = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic [6:0]            opcode,
    output logic [2:0]            f3,
    output logic [6:0]            f7,
    output logic [REG_W-1:0]      rs1,
    output logic [REG_W-1:0]      rs2,
    output logic [REG_W-1:0]      rd,
    output logic [4:0]            alu_op,
    output logic [2:0]            sx_op,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [DATA_WIDTH-1:0] unextended_data
);

    logic [6:0]            opcode_d, opcode_q;
    logic [2:0]            f3_d, f3_q;
    logic [6:0]            f7_d, f7_q;
    logic [REG_W-1:0]      rs1_d, rs1_q;
    logic [REG_W-1:0]      rs2_d, rs2_q;
    logic [REG_W-1:0]      rd_d, rd_q;
    logic [4:0]            alu_op_d, alu_op_q;
    logic [2:0]            sx_op_d, sx_op_q;
    logic                  mem_read_d, mem_read_q;
    logic                  mem_write_d, mem_write_q;
    logic                  reg_write_d, reg_write_q;
    logic [DATA_WIDTH-1:0] imm_d, imm_q;

    imm_extract #(.DATA_WIDTH(DATA_WIDTH)) u_imm_extract (
        .instruction (instruction),
        .imm         (imm_d)
    );

    always_comb begin
        opcode_d    = instruction[6:0];
        f3_d        = instruction[14:12];
        f7_d        = instruction[31:25];
        rs1_d       = '0;
        rs2_d       = '0;
        rd_d        = '0;
        alu_op_d    = ALU_INV;
        sx_op_d     = SX_NONE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        case (instruction[6:0])
            OP_LOAD: begin
                alu_op_d    = ALU_ADD;
                sx_op_d     = SX_I12;
                mem_read_d  = 1'b1;
                reg_write_d = 1'b1;
                rs1_d       = instruction[19:15];
                rd_d        = instruction[11:7];
            end
            OP_STORE: begin
                alu_op_d    = ALU_ADD;
                sx_op_d     = SX_I12;
                mem_write_d = 1'b1;
                rs1_d       = instruction[19:15];
                rs2_d       = instruction[24:20];
            end
            OP_BRANCH: begin
                alu_op_d = ALU_CMP;
                sx_op_d  = SX_I12;
                rs1_d    = instruction[19:15];
                rs2_d    = instruction[24:20];
            end
            OP_JAL: begin
                alu_op_d    = ALU_ADD;
                sx_op_d     = SX_J20;
                reg_write_d = 1'b1;
                rd_d        = instruction[11:7];
            end
            OP_JALR: begin
                alu_op_d    = ALU_ADD;
                sx_op_d     = SX_I12;
                reg_write_d = 1'b1;
                rs1_d       = instruction[19:15];
                rd_d        = instruction[11:7];
            end
            default: ;
        endcase
    end

    // Reset overrides the instruction, so an in-flight decode is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opcode_q    <= '0;
            f3_q        <= '0;
            f7_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_op_q    <= ALU_INV;
            sx_op_q     <= SX_NONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            imm_q       <= '0;
        end else begin
            opcode_q    <= opcode_d;
            f3_q        <= f3_d;
            f7_q        <= f7_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            alu_op_q    <= alu_op_d;
            sx_op_q     <= sx_op_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
            imm_q       <= imm_d;
        end
    end

    assign opcode          = opcode_q;
    assign f3              = f3_q;
    assign f7              = f7_q;
    assign rs1             = rs1_q;
    assign rs2             = rs2_q;
    assign rd              = rd_q;
    assign alu_op          = alu_op_q;
    assign sx_op           = sx_op_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign reg_write       = reg_write_q;
    assign unextended_data = imm_q;

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: directed vectors with literal expectations plus random
// instructions and reset pulses, all checked every cycle against a reference model.
module tb_decoder;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  alu_op;
        logic [2:0]  sx_op;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [31:0] imm;
    } exp_t;

    localparam int W = $bits(exp_t);

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [4:0]  alu_op;
    logic [2:0]  sx_op;
    logic        mem_read, mem_write, reg_write;
    logic [31:0] unextended_data;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    decoder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instruction     (instruction),
        .opcode          (opcode),
        .f3              (f3),
        .f7              (f7),
        .rs1             (rs1),
        .rs2             (rs2),
        .rd              (rd),
        .alu_op          (alu_op),
        .sx_op           (sx_op),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .reg_write       (reg_write),
        .unextended_data (unextended_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: fields picked out with shifts and masks from the ISA rules.
    function automatic exp_t model(input logic rst_low, input logic [31:0] i);
        exp_t e;
        int unsigned u;
        u           = i;
        e           = '0;
        e.alu_op    = 5'd7;
        e.sx_op     = 3'd7;
        if (rst_low) return e;
        e.opcode = 7'(u & 127);
        e.f3     = 3'((u >> 12) & 7);
        e.f7     = 7'(u >> 25);
        case (u & 127)
            3: begin   // load
                e.alu_op = 0; e.sx_op = 0; e.mem_read = 1; e.reg_write = 1;
                e.rs1 = 5'((u >> 15) & 31); e.rd = 5'((u >> 7) & 31);
                e.imm = u >> 20;
            end
            35: begin  // store
                e.alu_op = 0; e.sx_op = 0; e.mem_write = 1;
                e.rs1 = 5'((u >> 15) & 31); e.rs2 = 5'((u >> 20) & 31);
                e.imm = ((u >> 25) * 32) + ((u >> 7) & 31);
            end
            99: begin  // branch
                e.alu_op = 1; e.sx_op = 0;
                e.rs1 = 5'((u >> 15) & 31); e.rs2 = 5'((u >> 20) & 31);
                e.imm = ((u >> 31) * 2048) + (((u >> 7) & 1) * 1024)
                      + (((u >> 25) & 63) * 16) + ((u >> 8) & 15);
            end
            111: begin // jal
                e.alu_op = 0; e.sx_op = 6; e.reg_write = 1;
                e.rd = 5'((u >> 7) & 31);
                e.imm = ((u >> 31) * 524288) + (((u >> 12) & 255) * 2048)
                      + (((u >> 20) & 1) * 1024) + ((u >> 21) & 1023);
            end
            103: begin // jalr
                e.alu_op = 0; e.sx_op = 0; e.reg_write = 1;
                e.rs1 = 5'((u >> 15) & 31); e.rd = 5'((u >> 7) & 31);
                e.imm = u >> 20;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every rising edge produces one expected output set for the following cycle.
    always @(posedge clk) begin
        exp_q.push_back(W'(model(!rst_n, instruction)));
    end

    // scoreboard compare process
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            check("opcode",    32'(opcode),    32'(e.opcode));
            check("f3",        32'(f3),        32'(e.f3));
            check("f7",        32'(f7),        32'(e.f7));
            check("rs1",       32'(rs1),       32'(e.rs1));
            check("rs2",       32'(rs2),       32'(e.rs2));
            check("rd",        32'(rd),        32'(e.rd));
            check("alu_op",    32'(alu_op),    32'(e.alu_op));
            check("sx_op",     32'(sx_op),     32'(e.sx_op));
            check("mem_read",  32'(mem_read),  32'(e.mem_read));
            check("mem_write", 32'(mem_write), 32'(e.mem_write));
            check("reg_write", 32'(reg_write), 32'(e.reg_write));
            check("imm",       unextended_data, e.imm);
        end
    end

    // driver: present an instruction, then wait to the negedge where its decode is visible
    task automatic drive(input logic [31:0] instr);
        @(posedge clk);
        #1 instruction = instr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [6:0] ops [0:4];
        logic [31:0] r;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b1100011;
        ops[3] = 7'b1101111; ops[4] = 7'b1100111;

        rst_n       = 1'b0;
        instruction = 32'h00252283;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_alu_op", 32'(alu_op), 32'h7);
        check("rst_sx_op",  32'(sx_op),  32'h7);
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_mem_read", 32'(mem_read), 32'h0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lw_mem_read", 32'(mem_read), 32'h1);
        check("lw_rs1", 32'(rs1), 32'd10);
        check("lw_rd",  32'(rd),  32'd5);
        check("lw_imm", unextended_data, 32'd2);

        drive(32'hff770183);
        check("lb_rs1", 32'(rs1), 32'd14);
        check("lb_rd",  32'(rd),  32'd3);
        check("lb_imm", unextended_data, 32'hFF7);

        drive(32'hfea79123);
        check("sh_mem_write", 32'(mem_write), 32'h1);
        check("sh_rs2", 32'(rs2), 32'd10);
        check("sh_imm", unextended_data, 32'hFE2);

        drive(32'h002000ef);
        check("jal_sx_op", 32'(sx_op), 32'h6);
        check("jal_rd",    32'(rd),    32'd1);
        check("jal_imm",   unextended_data, 32'd1);

        drive(32'h001481e7);
        check("jalr_rs1", 32'(rs1), 32'd9);
        check("jalr_imm", unextended_data, 32'd1);

        drive(32'hfe761ee3);
        check("bne_alu_op", 32'(alu_op), 32'h1);
        check("bne_rs2", 32'(rs2), 32'd7);
        check("bne_imm", unextended_data, 32'hFFE);

        drive(32'hffffffff);
        check("ones_opcode", 32'(opcode), 32'h7F);
        check("ones_alu_op", 32'(alu_op), 32'h7);
        @(posedge clk);
        #1 instruction = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check("zero_opcode", 32'(opcode), 32'h0);
        check("zero_sx_op",  32'(sx_op),  32'h7);

        // random instructions, mostly supported opcodes, with occasional reset pulses
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 4)];
            instruction = r;
            rst_n = ($urandom_range(0, 19) != 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder.md
# decoder

Registered RV32 instruction decoder for the core's decode stage. It takes one 32-bit instruction word per cycle and emits the following, all registered:
- raw fields (opcode, f3, f7);
- register indices;
- memory and register-write control strobes;
- an ALU operation class;
- an immediate-extension selector;
- the right-justified raw immediate.

It supports load, store, branch, JAL and JALR. Every other opcode decodes as invalid with all side effects disabled.

## Interface
- DATA_WIDTH, 32: instruction and immediate width. Register index width is $clog2(DATA_WIDTH) = 5.
- clk  in  1  clock; all outputs update on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instruction  in  DATA_WIDTH  instruction word, sampled each rising edge.
- opcode  out  7  instruction[6:0], passed through for every opcode, valid or invalid.
- f3  out  3  instruction[14:12], always passed through.
- f7  out  7  instruction[31:25], always passed through.
- rs1, rs2, rd  out  5 each  register indices. Forced to 0 when the format has no such field.
- alu_op  out  5  ALU class: 5'b00000 = add (address/link), 5'b00001 = compare (branch), 5'b00111 = invalid.
- sx_op  out  3  extension selector: 3'b000 = sign-extend 12-bit field, 3'b110 = sign-extend 20-bit field, 3'b111 = none/invalid.
- mem_read  out  1  load.
- mem_write  out  1  store.
- reg_write  out  1  instruction writes rd.
- unextended_data  out  DATA_WIDTH  raw immediate, right-justified, zero in the upper bits.

## Operation
Decode is keyed on opcode. Columns below are alu_op / sx_op / mem_read / mem_write / reg_write, then fields used.
- Load, 0000011: 00000 / 000 / 1 / 0 / 1. rs1 = [19:15], rd = [11:7], rs2 = 0. Immediate = [31:20].
- Store, 0100011: 00000 / 000 / 0 / 1 / 0. rs1 = [19:15], rs2 = [24:20], rd = 0. Immediate = {[31:25],[11:7]}.
- Branch, 1100011: 00001 / 000 / 0 / 0 / 0. rs1, rs2 from their fields, rd = 0. Immediate = imm[12:1] = {[31],[7],[30:25],[11:8]}, in halfword units; the consumer shifts left by 1.
- JAL, 1101111: 00000 / 110 / 0 / 0 / 1. rd = [11:7], rs1 = rs2 = 0. Immediate = imm[20:1] = {[31],[19:12],[20],[30:21]}, in halfword units.
- JALR, 1100111: 00000 / 000 / 0 / 0 / 1. rs1 = [19:15], rd = [11:7], rs2 = 0. Immediate = [31:20].
- Any other opcode, including all-zeros and all-ones: alu_op 00111, sx_op 111, all strobes 0, rs1 = rs2 = rd = 0, unextended_data 0. opcode, f3 and f7 still pass through.
- f3 and f7 do not affect decode. Load/store widths and branch conditions are resolved downstream from f3.

## Timing
- One-cycle latency: outputs at edge N+1 reflect the instruction sampled at edge N. No stall or valid handshake; a new instruction is accepted every cycle.
- rst_n low at a rising edge loads these values, overriding the instruction:
  - alu_op = 5'b00111, sx_op = 3'b111;
  - opcode = 0, f3 = 0, f7 = 0;
  - rs1 = rs2 = rd = 0;
  - all strobes 0;
  - unextended_data = 0.
- Reset asserted mid-stream discards the in-flight decode.
- The first decode appears one edge after rst_n is sampled high.
- No internal state beyond the output registers.

## Structure
- Package decoder_pkg holds:
  - opcode localparams: OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR;
  - alu_op encodings: ALU_ADD, ALU_CMP, ALU_INV;
  - sx_op encodings: SX_I12, SX_J20, SX_NONE.
- Sub-module imm_extract: combinational; takes the instruction and returns the right-justified raw immediate per format, or 0 for invalid.
- Top level: a combinational decode case feeding one always_ff output register bank with synchronous reset.

## Test plan
- Reset: hold rst_n low for 2 cycles with instruction 0x00252283 -> all outputs at their reset values. Release rst_n -> one edge later, the load decode below.
- lw x5,2(x10), 0x00252283 -> opcode 0000011, alu_op 0, sx_op 000, mem_read 1, reg_write 1, mem_write 0, rs1 10, rs2 0, rd 5, unextended_data 2. Repeat for lb 0xff770183 -> rs1 14, rd 3, unextended_data 0xFF7.
- sh x10,-30(x15), 0xfea79123 -> opcode 0100011, mem_write 1, reg_write 0, rs1 15, rs2 10, rd 0, unextended_data 0xFE2.
- jal x1,2, 0x002000ef -> sx_op 110, reg_write 1, rd 1, rs1 = rs2 = 0, unextended_data 1. jalr x3,1(x9), 0x001481e7 -> sx_op 000, rs1 9, rd 3, unextended_data 1.
- bne x12,x7,-4, 0xfe761ee3 -> alu_op 00001, strobes 0, rs1 12, rs2 7, rd 0, unextended_data 0xFFE.
- Back-to-back 0xFFFFFFFF then 0x00000000 -> invalid decode each cycle with opcode 1111111 then 0000000, all strobes 0, alu_op 00111, sx_op 111.
